rep_sequencer: RTL

REP_SEQUENCER -- requirements
Module: rep_sequencer

---
 rtl/decode_pkg.sv | 25 ++
 rtl/rep_sequencer_if.sv | 27 ++
 rtl/rep_counter.sv | 30 +++
 rtl/rep_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants for the repeat-string sequencer: FSM states, REP prefix codes,
// ECX writeback target and operand size.
package decode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_ZF    = 3'd3,
        ST_WAIT_DRAIN = 3'd4
    } rep_state_t;

    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_E    = 2'b01;
    localparam logic [1:0] REP_NE   = 2'b10;

    localparam logic [2:0] ECX_REG    = 3'b001;
    localparam logic [2:0] DWORD_SIZE = 3'd3;

    // REPE/REP stops on ZF=0, REPNE stops on ZF=1.
    function automatic logic zf_terminates(input logic [1:0] rep, input logic zf);
        return ((rep == REP_E) && !zf) || ((rep == REP_NE) && zf);
    endfunction

endpackage

// File: rtl/rep_sequencer_if.sv
// Decoded-instruction, issue and ECX-writeback handshakes of the repeat-string sequencer.
// master = sequencer side, slave = surrounding pipeline.
interface rep_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_rep;
    logic        in_string;
    logic        in_zf_check;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_idle;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [31:0] wb_data;
    logic [2:0]  wb_size;

    modport master (
        input  in_valid, in_rep, in_string, in_zf_check, out_ready, out_idle,
        output in_ready, out_valid, out_last, wb_valid, wb_reg, wb_data, wb_size
    );

    modport slave (
        output in_valid, in_rep, in_string, in_zf_check, out_ready, out_idle,
        input  in_ready, out_valid, out_last, wb_valid, wb_reg, wb_data, wb_size
    );
endinterface

// File: rtl/rep_counter.sv
// Remaining-iteration counter for the repeat-string sequencer: load from ECX,
// decrement per accepted iteration, zero/one compares.
module rep_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        dec,
    input  logic [31:0] load_val,
    output logic [31:0] count,
    output logic [31:0] count_dec,
    output logic        load_is_zero,
    output logic        is_one
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count_dec;
        end
    end

    assign count_dec    = count - 32'd1;
    assign is_one       = (count == 32'd1);
    assign load_is_zero = (load_val == '0);

endmodule

// File: rtl/rep_sequencer.sv
// REP-prefixed string instruction sequencer: expands one decoded instruction into ECX
// iterations with ECX writeback. Optional ZF termination under `REP_ZF_TERMINATE_EN.
module rep_sequencer
    import decode_pkg::*;
#(
    parameter logic SINGLE_TXN = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    rep_sequencer_if.master bus,
    input  logic [31:0]     ecx_in,
    input  logic            ecx_valid,
    input  logic            zf_in,
    input  logic            zf_valid,
    input  logic            pending_int,
    output logic            hold_int,
    output logic            int_yield,
    output logic            busy
);

    rep_state_t  state;
    rep_state_t  state_nxt;
    logic        valid_held;
    logic        wb_valid_q;
    logic [31:0] wb_data_q;
    logic        int_yield_q;
    logic        busy_q;

    logic        is_rep_req;
    logic        accept;
    logic        yield_now;
    logic        cnt_load;
    logic [31:0] count;
    logic [31:0] count_dec;
    logic        load_is_zero;
    logic        cnt_is_one;
    logic        zf_active;
    logic        zf_ready;
    logic        zf_term;

`ifdef REP_ZF_TERMINATE_EN
    assign zf_active = bus.in_zf_check;
    assign zf_ready  = zf_valid;
    assign zf_term   = zf_valid && zf_terminates(bus.in_rep, zf_in);
`else
    logic unused_zf;
    assign zf_active = 1'b0;
    assign zf_ready  = 1'b1;
    assign zf_term   = 1'b0;
    assign unused_zf = ^{zf_in, zf_valid, bus.in_zf_check};
`endif

    assign is_rep_req = bus.in_string && (bus.in_rep != REP_NONE);
    assign accept     = (state == ST_ISSUE) && bus.out_valid && bus.out_ready;
    assign cnt_load   = (state == ST_LOAD) && ecx_valid && !flush;
    assign yield_now  = !flush && pending_int &&
                        (((state == ST_ISSUE) && !accept) || (state == ST_WAIT_DRAIN));

    rep_counter u_counter (
        .clk          (clk),
        .reset        (reset),
        .clear        (flush),
        .load         (cnt_load),
        .dec          (accept),
        .load_val     (ecx_in),
        .count        (count),
        .count_dec    (count_dec),
        .load_is_zero (load_is_zero),
        .is_one       (cnt_is_one)
    );

    always_comb begin
        bus.out_valid = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_last  = 1'b0;
        hold_int      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!is_rep_req) begin
                    bus.out_valid = bus.in_valid;
                    bus.in_ready  = bus.out_ready;
                    bus.out_last  = 1'b1;
                end
            end
            ST_LOAD: begin
                hold_int     = 1'b1;
                bus.in_ready = ecx_valid && load_is_zero;
            end
            ST_ISSUE: begin
                // A fresh issue yields to a pending interrupt; an outstanding one is only
                // withdrawn if the consumer is not taking it this cycle.
                bus.out_valid = valid_held ? !(pending_int && !bus.out_ready) : !pending_int;
                bus.out_last  = cnt_is_one;
                hold_int      = bus.out_valid && !bus.out_ready;
                bus.in_ready  = bus.out_valid && bus.out_ready && cnt_is_one;
            end
            ST_WAIT_ZF: begin
                bus.in_ready = zf_term;
            end
            default: ;
        endcase
        if (flush) begin
            bus.out_valid = 1'b0;
            bus.in_ready  = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.in_valid && is_rep_req) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (ecx_valid) state_nxt = load_is_zero ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (accept) begin
                    if (cnt_is_one)      state_nxt = ST_IDLE;
                    else if (zf_active)  state_nxt = ST_WAIT_ZF;
                    else if (SINGLE_TXN) state_nxt = ST_WAIT_DRAIN;
                end else if (pending_int) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_ZF: begin
                if (zf_term)       state_nxt = ST_IDLE;
                else if (zf_ready) state_nxt = SINGLE_TXN ? ST_WAIT_DRAIN : ST_ISSUE;
            end
            ST_WAIT_DRAIN: begin
                if (pending_int)       state_nxt = ST_IDLE;
                else if (bus.out_idle) state_nxt = ST_ISSUE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            valid_held  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            int_yield_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            valid_held  <= (state == ST_ISSUE) && bus.out_valid && !bus.out_ready && !flush;
            wb_valid_q  <= accept;
            int_yield_q <= yield_now;
            busy_q      <= (state_nxt != ST_IDLE);
            if (accept) wb_data_q <= count_dec;
        end
    end

    assign bus.wb_valid = wb_valid_q && !flush;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_reg   = ECX_REG;
    assign bus.wb_size  = DWORD_SIZE;
    assign int_yield    = int_yield_q && !flush;
    assign busy         = busy_q;

endmodule
